sram_model_ws: RTL and testbench
================================

// Module: sram_model_ws
// PURPOSE
//  Parametrised behavioural external-SRAM model with active-low chip controls and per-byte lane enables.
//  Adds configurable read latency (wait states) and a post-reset clearing sweep that reports when it finishes.
//  Flags bus conflicts. Sits on the board side of the SRAM controller in cache/memory testbenches.
//  Also sizes memory for larger test programs.
// PARAMETERS
//  DATA_W          16  data bus width, multiple of 8
//  ADDR_W          18  external address bus width
//  DEPTH_LOG2      11  log2 of implemented words (DEPTH = 2**DEPTH_LOG2); upper address bits ignored (aliasing)
//  RD_LAT           1  negedges from read capture to DQ valid; 0 = combinational read
//  CLEAR_ON_RESET   1  1 = zero every word after reset via sweep; 0 = contents retained, no sweep
// PORTS
//  clk          in     1                 clock; all state updates on negedge clk
//  rst          in     1                 reset
//  SRAM_DQ      inout  DATA_W            bidirectional data bus; Z when not driving
//  SRAM_ADDR    in     ADDR_W            word address
//  SRAM_CE_N    in     1                 chip enable, active-low
//  SRAM_OE_N    in     1                 output enable, active-low
//  SRAM_WE_N    in     1                 write enable, active-low
//  SRAM_BE_N    in     DATA_W/8          byte-lane enables, active-low; bit i covers DQ[8i+7:8i]
//  init_busy    out    1                 clearing sweep in progress; accesses ignored
//  conflict_err out    1                 sticky: OE_N and WE_N both low with CE_N low at a negedge
// BEHAVIOUR
//  Reset: rst, asynchronous, active-high.
//   - Effects of rst: sweep_cnt=0; read pipe valid bits all 0; DQ=Z; conflict_err=0.
//   - CLEAR_ON_RESET=1: state=CLEAR, init_busy=1.
//   - CLEAR_ON_RESET=0: state=IDLE, init_busy=0.
//   - rst mid-sweep or mid-read restarts from these values.
//  FSM CLEAR -> IDLE:
//   - CLEAR writes 0 to mem[sweep_cnt] each negedge, then increments sweep_cnt.
//   - On the edge that writes DEPTH-1, the FSM moves to IDLE and init_busy falls.
//   - init_busy is therefore high for exactly DEPTH negedges.
//   - In CLEAR, bus accesses are ignored, DQ=Z, and conflict_err is not updated.
//  Index: idx = SRAM_ADDR[DEPTH_LOG2-1:0].
//  Write (IDLE, CE_N=0, WE_N=0) at negedge:
//   - For each lane i with BE_N[i]=0: mem[idx][8i+:8] <= DQ[8i+:8]. Other lanes keep their value.
//   - A write flushes the read pipe.
//  Read (IDLE, CE_N=0, OE_N=0, WE_N=1):
//   - RD_LAT=0: DQ = mem[idx] combinationally.
//   - RD_LAT>=1: stage 0 captures {valid=1, mem[idx]} each negedge; the pipe shifts one stage per negedge.
//   - DQ drives last-stage data when it is valid and CE_N=0, OE_N=0, WE_N=1.
//   - Back-to-back reads with changing address stream one word per cycle. DQ shows the word addressed RD_LAT edges earlier.
//   - Data is captured at capture time. A later write does not alter words already in the pipe.
//  Lane tristate: lanes with BE_N[i]=1 are Z even during a valid read.
//  Flush:
//   - CE_N=1 or OE_N=1 makes DQ Z combinationally.
//   - The same condition clears all valid bits at the next negedge, so a re-assertion waits RD_LAT edges again.
//  Conflict (IDLE, CE_N=0, OE_N=0, WE_N=0):
//   - The write is performed and DQ is not driven by the model.
//   - conflict_err sets at that negedge and holds until rst.
//  CE_N=1: no write, no capture, DQ=Z.
// STRUCTURE
//  sram_pkg holds:
//   - state enum {ST_CLEAR, ST_IDLE};
//   - LANE_W=8 and a lanes(DATA_W) function;
//   - default DATA_W/ADDR_W/DEPTH_LOG2 constants shared with the SRAM controller.
//  Sub-module sram_rd_pipe: parametrised RD_LAT-stage {valid,data} shift register with flush.
//   - RD_LAT=0 instantiates a pass-through.
//  Top level holds the memory array, the FSM with sweep counter, the lane write logic, the DQ tristate and the conflict flag.
// TESTING
//  1. Clearing sweep: rst pulse with CLEAR_ON_RESET=1, DEPTH_LOG2=4 -> init_busy high exactly 16 negedges.
//     Then read of idx 0..15 -> 0x0000. A write during busy -> no effect.
//  2. Byte lanes: write 0xABCD to addr 5 with BE_N=00, then 0x1200 with BE_N=01.
//     Read with BE_N=00 -> 0x12CD. Read with BE_N=10 -> DQ = 8'hZZ,8'hCD.
//  3. Latency: RD_LAT=2, reads of addr 1,2,3 on consecutive negedges (mem=0x11,0x22,0x33).
//     DQ is Z for 2 edges, then 0x11,0x22,0x33 on successive cycles.
//  4. Flush: OE_N pulsed high for one cycle mid-stream -> DQ Z immediately, and valid data returns RD_LAT edges after OE_N low.
//  5. Conflict: CE_N=0, OE_N=0, WE_N=0, addr 7, DQ driven 0x5A5A by the TB.
//     -> conflict_err=1 sticky and mem[7]=0x5A5A. rst clears conflict_err.
//  6. Aliasing and async reset: write 0x7777 to SRAM_ADDR=0x00805 -> read at 0x00005 returns 0x7777.
//     rst asserted mid-read -> DQ Z without a clock edge.

Source files
------------

// File: rtl/sram_model_ws_pkg.sv
// Shared definitions for the behavioural external-SRAM model.
// Holds the FSM state type, the byte-lane width and the default bus geometry
// shared with the SRAM controller, plus a helper that turns a data width into
// a lane count.
package sram_model_ws_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int LANE_W          = 8;
    localparam int SRAM_DATA_W     = 16;
    localparam int SRAM_ADDR_W     = 18;
    localparam int SRAM_DEPTH_LOG2 = 11;

    function automatic int lanes(input int data_w);
        return data_w / LANE_W;
    endfunction

endpackage

// File: rtl/sram_model_ws_if.sv
// Board-side SRAM control bus: address, active-low chip/output/write enables
// and active-low byte-lane enables.
// The bidirectional data bus stays a direct inout port on the model, so the
// tristate drivers sit on plain module ports rather than inside an interface.
// Modports: master = SRAM controller / bench (drives), slave = SRAM model.
interface sram_model_ws_if
    import sram_model_ws_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int ADDR_W = SRAM_ADDR_W
);
    logic [ADDR_W-1:0]        SRAM_ADDR;
    logic                     SRAM_CE_N;
    logic                     SRAM_OE_N;
    logic                     SRAM_WE_N;
    logic [lanes(DATA_W)-1:0] SRAM_BE_N;

    modport master (
        output SRAM_ADDR,
        output SRAM_CE_N,
        output SRAM_OE_N,
        output SRAM_WE_N,
        output SRAM_BE_N
    );

    modport slave (
        input SRAM_ADDR,
        input SRAM_CE_N,
        input SRAM_OE_N,
        input SRAM_WE_N,
        input SRAM_BE_N
    );
endinterface

// File: rtl/sram_model_ws_rd_pipe.sv
// Read-latency pipe: RD_LAT stages of {valid, data}, shifting on negedge clk.
// flush clears every valid bit at the next edge; rst clears them at once.
// RD_LAT = 0 degenerates to a combinational pass-through.
// Ports:
//   clk, rst           clock (negedge active), async active-high reset
//   in_valid, in_data  stage-0 capture
//   flush              drop everything in flight
//   out_valid, out_data last stage
module sram_model_ws_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    if (RD_LAT == 0) begin : g_pass
        logic unused_ctl;
        assign unused_ctl = clk ^ rst ^ flush;
        assign out_valid  = in_valid;
        assign out_data   = in_data;
    end else begin : g_pipe
        logic [RD_LAT-1:0] vld;
        logic [DATA_W-1:0] dat [RD_LAT];

        always_ff @(negedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
            end else if (flush) begin
                vld <= '0;
            end else begin
                vld[0] <= in_valid;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
        end

        // Data needs no reset: it is only ever observed behind its valid bit.
        always_ff @(negedge clk) begin
            dat[0] <= in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                dat[i] <= dat[i-1];
            end
        end

        assign out_valid = vld[RD_LAT-1];
        assign out_data  = dat[RD_LAT-1];
    end
endmodule

// File: rtl/sram_model_ws.sv
// Behavioural external SRAM with per-byte lane enables, configurable read
// latency, an optional post-reset zeroing sweep and a sticky bus-conflict flag.
// All state updates on negedge clk.
// Ports:
//   clk, rst      clock, async active-high reset
//   bus           control bus (slave modport): ADDR, CE_N, OE_N, WE_N, BE_N
//   SRAM_DQ       bidirectional data, Z per lane when not driving
//   init_busy     zeroing sweep in progress; accesses ignored
//   conflict_err  sticky: OE_N and WE_N low together with CE_N low
//
// state    | meaning
// ST_CLEAR | zeroing mem[sweep_cnt] each edge, bus ignored, init_busy high
// ST_IDLE  | normal read/write service
module sram_model_ws
    import sram_model_ws_pkg::*;
#(
    parameter int DATA_W         = SRAM_DATA_W,
    parameter int ADDR_W         = SRAM_ADDR_W,
    parameter int DEPTH_LOG2     = SRAM_DEPTH_LOG2,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_model_ws_if.slave    bus,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              init_busy,
    output logic              conflict_err
);
    localparam int NLANE = lanes(DATA_W);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_t                  state;
    logic [DEPTH_LOG2-1:0]   sweep_cnt;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    sel;
    logic                    wr_en;
    logic                    rd_en;
    logic                    conflict_now;
    logic                    pipe_valid;
    logic [DATA_W-1:0]       pipe_data;
    logic [NLANE-1:0]        dq_oe;

    // Upper address bits alias onto the implemented depth.
    assign idx = bus.SRAM_ADDR[DEPTH_LOG2-1:0];
    if (ADDR_W > DEPTH_LOG2) begin : g_alias
        logic unused_addr;
        assign unused_addr = ^bus.SRAM_ADDR[ADDR_W-1:DEPTH_LOG2];
    end

    assign sel          = (state == ST_IDLE) && !bus.SRAM_CE_N;
    assign wr_en        = sel && !bus.SRAM_WE_N;
    assign rd_en        = sel && !bus.SRAM_OE_N && bus.SRAM_WE_N;
    assign conflict_now = sel && !bus.SRAM_OE_N && !bus.SRAM_WE_N;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state        <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            sweep_cnt    <= '0;
            init_busy    <= (CLEAR_ON_RESET != 0);
            conflict_err <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == {DEPTH_LOG2{1'b1}}) begin
                        state     <= ST_IDLE;
                        init_busy <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (conflict_now) begin
                        conflict_err <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A conflicting cycle still writes; only the read side is suppressed.
    always_ff @(negedge clk) begin
        if (state == ST_CLEAR) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NLANE; i++) begin
                if (!bus.SRAM_BE_N[i]) begin
                    mem[idx][i*LANE_W +: LANE_W] <= SRAM_DQ[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Any non-read edge (write, CE_N/OE_N high, sweep) empties the pipe, so a
    // fresh read always pays the full latency again.
    sram_model_ws_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_data   (mem[idx]),
        .flush     (!rd_en),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // rst gates the drivers directly so the bus releases without a clock edge.
    always_comb begin
        dq_oe = '0;
        for (int i = 0; i < NLANE; i++) begin
            dq_oe[i] = pipe_valid && rd_en && !rst && !bus.SRAM_BE_N[i];
        end
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        assign SRAM_DQ[g*LANE_W +: LANE_W] = dq_oe[g] ? pipe_data[g*LANE_W +: LANE_W]
                                                      : {LANE_W{1'bz}};
    end
endmodule

// File: tb/tb_sram_model_ws.sv
module tb_sram_model_ws;
    localparam int DW    = 16;
    localparam int AW    = 18;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_model_ws_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wire  [DW-1:0] dq;
    logic [DW-1:0] tb_dq = '0;
    logic          tb_drv = 1'b0;
    logic          init_busy;
    logic          conflict_err;

    assign dq = tb_drv ? tb_dq : {DW{1'bz}};

    sram_model_ws #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .DEPTH_LOG2     (DL),
        .RD_LAT         (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .SRAM_DQ      (dq),
        .init_busy    (init_busy),
        .conflict_err (conflict_err)
    );

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory is all-zero after reset, the bus is dead for
    // DEPTH edges, and a read shows the word captured LAT-1 edges before the
    // most recent one, provided the last LAT edges were all read edges.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt  = 0;
    logic          m_conf = 1'b0;
    logic [DW-1:0] m_q [$];

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_cnt  = 0;
            m_conf = 1'b0;
            m_q.delete();
        end else if (m_cnt < DEPTH) begin
            m_cnt++;
        end else begin
            int a;
            a = int'(bus.SRAM_ADDR[DL-1:0]);
            if (!bus.SRAM_CE_N && !bus.SRAM_WE_N) begin
                for (int l = 0; l < 2; l++)
                    if (!bus.SRAM_BE_N[l]) m_mem[a][8*l +: 8] = tb_dq[8*l +: 8];
                if (!bus.SRAM_OE_N) m_conf = 1'b1;
            end
            if (!bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N) begin
                m_q.push_back(m_mem[a]);
                if (m_q.size() > LAT) void'(m_q.pop_front());
            end else begin
                m_q.delete();
            end
        end
    end

    always @(posedge clk) begin
        if (cmp_en) begin
            logic [1:0]    eo;
            logic [DW-1:0] w;
            logic          drive;
            drive = !rst && (m_cnt >= DEPTH) && !bus.SRAM_CE_N && !bus.SRAM_OE_N
                    && bus.SRAM_WE_N && (m_q.size() == LAT);
            eo = drive ? ~bus.SRAM_BE_N : 2'b00;
            w  = drive ? m_q[0] : '0;
            chk("busy", 32'(init_busy), 32'(m_cnt < DEPTH));
            chk("conflict", 32'(conflict_err), 32'(m_conf));
            chk("lane_oe", 32'(dut.dq_oe), 32'(eo));
            for (int l = 0; l < 2; l++)
                if (eo[l]) chk("dq_lane", 32'(dq[8*l +: 8]), 32'(w[8*l +: 8]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_bus(input logic ce, input logic oe, input logic we,
                           input logic [1:0] be, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.SRAM_CE_N = ce;
        bus.SRAM_OE_N = oe;
        bus.SRAM_WE_N = we;
        bus.SRAM_BE_N = be;
        bus.SRAM_ADDR = a;
        tb_dq         = d;
        tb_drv        = !we;
    endtask

    task automatic idle();
        set_bus(1'b1, 1'b1, 1'b1, 2'b11, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        set_bus(1'b0, 1'b1, 1'b0, be, a, d);
        step();
        idle();
    endtask

    task automatic rd_set(input logic [AW-1:0] a, input logic [1:0] be);
        set_bus(1'b0, 1'b0, 1'b1, be, a, '0);
    endtask

    // Counts negedges from reset release until init_busy falls.
    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (init_busy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        step();
        step();
        cmp_en = 1'b1;
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_conf", 32'(conflict_err), 32'd0);

        // Clearing sweep with a write attempt held throughout.
        set_bus(1'b0, 1'b1, 1'b0, 2'b00, 18'd3, 16'hBEEF);
        rst = 1'b0;
        wait_busy("busy_len");
        idle();
        step();
        rd_set(18'd3, 2'b00);
        step();
        step();
        chk("clr_rd3", 32'(dq), 32'h0000);
        for (int i = 0; i < DEPTH; i++) begin
            rd_set(AW'(i), 2'b00);
            step();
        end
        step();
        step();
        idle();
        step();

        // Byte lanes.
        wr(18'd5, 16'hABCD, 2'b00);
        wr(18'd5, 16'h1200, 2'b01);
        rd_set(18'd5, 2'b00);
        step();
        step();
        chk("lane_rd", 32'(dq), 32'h12CD);
        bus.SRAM_BE_N = 2'b10;
        #1;
        chk("lane_hi_z", 32'(dut.dq_oe), 32'b01);
        chk("lane_lo", 32'(dq[7:0]), 32'hCD);
        idle();
        step();

        // Latency streaming.
        wr(18'd1, 16'h0011, 2'b00);
        wr(18'd2, 16'h0022, 2'b00);
        wr(18'd3, 16'h0033, 2'b00);
        rd_set(18'd1, 2'b00);
        chk("lat_z0", 32'(dut.dq_oe), 32'd0);
        step();
        rd_set(18'd2, 2'b00);
        chk("lat_z1", 32'(dut.dq_oe), 32'd0);
        step();
        rd_set(18'd3, 2'b00);
        chk("lat_w1", 32'(dq), 32'h0011);
        step();
        chk("lat_w2", 32'(dq), 32'h0022);
        step();
        chk("lat_w3", 32'(dq), 32'h0033);

        // Flush by an OE_N pulse.
        bus.SRAM_OE_N = 1'b1;
        #1;
        chk("flush_z", 32'(dut.dq_oe), 32'd0);
        step();
        bus.SRAM_OE_N = 1'b0;
        #1;
        chk("flush_wait0", 32'(dut.dq_oe), 32'd0);
        step();
        chk("flush_wait1", 32'(dut.dq_oe), 32'd0);
        step();
        chk("flush_back", 32'(dq), 32'h0033);
        idle();
        step();

        // Conflict.
        set_bus(1'b0, 1'b0, 1'b0, 2'b00, 18'd7, 16'h5A5A);
        #1;
        chk("conf_pre", 32'(conflict_err), 32'd0);
        step();
        chk("conf_set", 32'(conflict_err), 32'd1);
        chk("conf_noz", 32'(dut.dq_oe), 32'd0);
        idle();
        step();
        chk("conf_sticky", 32'(conflict_err), 32'd1);
        rd_set(18'd7, 2'b00);
        step();
        step();
        chk("conf_mem", 32'(dq), 32'h5A5A);
        idle();
        step();
        rst = 1'b1;
        #1;
        chk("conf_rst", 32'(conflict_err), 32'd0);
        step();
        rst = 1'b0;
        wait_busy("busy_len2");
        idle();
        step();

        // Aliasing, then async reset mid-read.
        wr(18'h00805, 16'h7777, 2'b00);
        rd_set(18'h00005, 2'b00);
        step();
        step();
        chk("alias", 32'(dq), 32'h7777);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_z", 32'(dut.dq_oe), 32'd0);
        chk("rst_busy2", 32'(init_busy), 32'd1);
        step();
        rst = 1'b0;
        wait_busy("busy_len3");
        step();
        step();
        chk("post_rst_clr", 32'(dq), 32'h0000);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
